// File: rtl/cv32e40x_controller_scoreboard_pkg.sv
// Shared types and constants for the controller register scoreboard.
package cv32e40x_controller_scoreboard_pkg;

    // Register file address width (x0..x31)
    localparam int SB_ADDR_W = 5;

    // Widest transaction id an entry can hold; narrower ids are zero-extended
    localparam int SB_ID_MAX_W = 8;

    // One scoreboard slot: an in-flight long-latency writeback
    typedef struct packed {
        logic                   valid;
        logic                   we;
        logic [SB_ADDR_W-1:0]   waddr;
        logic [SB_ID_MAX_W-1:0] id;
    } sb_entry_t;

    // An entry can only cause hazards if it really writes a register other than x0
    function automatic logic sb_tracked(sb_entry_t e);
        return e.valid && e.we && (e.waddr != '0);
    endfunction

endpackage

// File: rtl/cv32e40x_controller_scoreboard_if.sv
// Issue / read-port / retire / status bundle between ID stage and scoreboard.
interface cv32e40x_controller_scoreboard_if
    import cv32e40x_controller_scoreboard_pkg::*;
#(
    parameter int REGFILE_NUM_READ_PORTS = 2,
    parameter int DEPTH                  = 4,
    parameter int ID_WIDTH               = 4
);
    logic                                              issue_valid_i;
    logic                                              issue_ready_o;
    logic                                              issue_we_i;
    logic [SB_ADDR_W-1:0]                              issue_waddr_i;
    logic [ID_WIDTH-1:0]                               issue_id_i;
    logic [REGFILE_NUM_READ_PORTS-1:0]                 rf_re_id_i;
    logic [REGFILE_NUM_READ_PORTS-1:0][SB_ADDR_W-1:0]  rf_raddr_id_i;
    logic                                              retire_valid_i;
    logic [ID_WIDTH-1:0]                               retire_id_i;
    logic                                              raw_hazard_o;
    logic                                              waw_hazard_o;
    logic                                              stall_id_o;
    logic                                              full_o;
    logic                                              empty_o;
    logic [$clog2(DEPTH+1)-1:0]                        outstanding_o;

    // Controller / ID side
    modport master (
        output issue_valid_i, issue_we_i, issue_waddr_i, issue_id_i,
        output rf_re_id_i, rf_raddr_id_i, retire_valid_i, retire_id_i,
        input  issue_ready_o, raw_hazard_o, waw_hazard_o, stall_id_o,
        input  full_o, empty_o, outstanding_o
    );

    // Scoreboard side
    modport slave (
        input  issue_valid_i, issue_we_i, issue_waddr_i, issue_id_i,
        input  rf_re_id_i, rf_raddr_id_i, retire_valid_i, retire_id_i,
        output issue_ready_o, raw_hazard_o, waw_hazard_o, stall_id_o,
        output full_o, empty_o, outstanding_o
    );

endinterface

// File: rtl/cv32e40x_controller_scoreboard_ff_one.sv
// Lowest-set-bit finder used to pick the first free scoreboard slot.
module cv32e40x_ff_one #(
    parameter int LEN = 4
) (
    input  logic [LEN-1:0]                       in_i,
    output logic [((LEN > 1) ? $clog2(LEN) : 1)-1:0] first_one_o,
    output logic                                 no_ones_o
);
    localparam int W = (LEN > 1) ? $clog2(LEN) : 1;

    // Scan from the top down so the lowest set bit wins
    always_comb begin
        first_one_o = '0;
        no_ones_o   = 1'b1;
        for (int i = LEN - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                first_one_o = W'(i);
                no_ones_o   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cv32e40x_controller_scoreboard.sv
// Register scoreboard: tracks in-flight long-latency writebacks by id and
// raises RAW/WAW hazards against them so ID can stall.
module cv32e40x_controller_scoreboard
    import cv32e40x_controller_scoreboard_pkg::*;
#(
    parameter int REGFILE_NUM_READ_PORTS = 2,
    parameter int DEPTH                  = 4,
    parameter int ID_WIDTH               = 4
) (
    input logic                            clk,
    input logic                            rst_n,
    cv32e40x_controller_scoreboard_if.slave sb
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OUT_W = $clog2(DEPTH + 1);

    sb_entry_t              entries [DEPTH];
    logic [DEPTH-1:0]       valid;
    logic [DEPTH-1:0]       retiring;
    logic [DEPTH-1:0]       tracked;
    logic [IDX_W-1:0]       free_idx;
    logic                   no_free;
    logic                   accept;
    logic                   raw;
    logic                   waw;
    logic [OUT_W-1:0]       count;
    logic                   retire_hit;
    logic                   dup_id;

    // Per-slot view: which entries are valid, being retired now, or can cause hazards
    always_comb begin
        valid    = '0;
        retiring = '0;
        tracked  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i]    = entries[i].valid;
            retiring[i] = sb.retire_valid_i && entries[i].valid &&
                          (entries[i].id == SB_ID_MAX_W'(sb.retire_id_i));
            tracked[i]  = sb_tracked(entries[i]) && !retiring[i];
        end
    end

    cv32e40x_ff_one #(
        .LEN (DEPTH)
    ) u_free_slot (
        .in_i        (~valid),
        .first_one_o (free_idx),
        .no_ones_o   (no_free)
    );

    // RAW against enabled non-x0 read ports, WAW against the offered rd
    always_comb begin
        raw = 1'b0;
        waw = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int p = 0; p < REGFILE_NUM_READ_PORTS; p++) begin
                if (sb.rf_re_id_i[p] && (sb.rf_raddr_id_i[p] != '0) &&
                    tracked[i] && (entries[i].waddr == sb.rf_raddr_id_i[p])) begin
                    raw = 1'b1;
                end
            end
            if (sb.issue_we_i && (sb.issue_waddr_i != '0) &&
                tracked[i] && (entries[i].waddr == sb.issue_waddr_i)) begin
                waw = 1'b1;
            end
        end
    end

    // Occupancy count; x0 and no-write entries still hold a slot
    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + OUT_W'(valid[i]);
        end
    end

    // Status outputs; full deliberately ignores a same-cycle retire
    always_comb begin
        sb.full_o        = no_free;
        sb.empty_o       = (valid == '0);
        sb.outstanding_o = count;
        sb.raw_hazard_o  = raw;
        sb.waw_hazard_o  = waw;
        sb.issue_ready_o = !no_free && !waw;
        accept           = sb.issue_valid_i && !no_free && !waw;
        sb.stall_id_o    = raw || (sb.issue_valid_i && !sb.issue_ready_o);
    end

    // Entry array: reset wipes everything, else retire clears and accept fills the free slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (retiring[i]) begin
                    entries[i].valid <= 1'b0;
                end
                if (accept && (free_idx == IDX_W'(i))) begin
                    entries[i].valid <= 1'b1;
                    entries[i].we    <= sb.issue_we_i;
                    entries[i].waddr <= sb.issue_waddr_i;
                    entries[i].id    <= SB_ID_MAX_W'(sb.issue_id_i);
                end
            end
        end
    end

    // Protocol checks: retire must hit a valid id, and ids among valid entries are unique
    always_comb begin
        retire_hit = |retiring;
        dup_id     = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = i + 1; j < DEPTH; j++) begin
                if (entries[i].valid && entries[j].valid && (entries[i].id == entries[j].id)) begin
                    dup_id = 1'b1;
                end
            end
        end
    end

    a_retire_hits_valid_id: assert property (
        @(posedge clk) disable iff (!rst_n) sb.retire_valid_i |-> retire_hit);

    a_ids_unique: assert property (
        @(posedge clk) disable iff (!rst_n) !dup_id);

    a_no_retire_of_issuing_id: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(accept && sb.retire_valid_i && (sb.retire_id_i == sb.issue_id_i)));

endmodule

// File: tb/tb_cv32e40x_controller_scoreboard.sv
// Directed self-checking bench for the controller register scoreboard.
module tb_cv32e40x_controller_scoreboard;
    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    cv32e40x_controller_scoreboard_if #(
        .REGFILE_NUM_READ_PORTS (2),
        .DEPTH                  (4),
        .ID_WIDTH               (4)
    ) sb_if ();

    cv32e40x_controller_scoreboard #(
        .REGFILE_NUM_READ_PORTS (2),
        .DEPTH                  (4),
        .ID_WIDTH               (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs at the falling edge, then let combinational outputs settle
    task automatic apply_stimulus(input logic rn, input logic iv, input logic we,
                                  input logic [4:0] wa, input logic [3:0] id,
                                  input logic [1:0] re, input logic [4:0] ra0,
                                  input logic [4:0] ra1, input logic rv,
                                  input logic [3:0] rid);
        @(negedge clk);
        rst_n                   = rn;
        sb_if.issue_valid_i     = iv;
        sb_if.issue_we_i        = we;
        sb_if.issue_waddr_i     = wa;
        sb_if.issue_id_i        = id;
        sb_if.rf_re_id_i        = re;
        sb_if.rf_raddr_id_i[0]  = ra0;
        sb_if.rf_raddr_id_i[1]  = ra1;
        sb_if.retire_valid_i    = rv;
        sb_if.retire_id_i       = rid;
        #1;
    endtask

    // Compare one observed value with its hand-computed expectation
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Linear directed sequence
    initial begin
        compared   = 0;
        mismatched = 0;

        rst_n                  = 1'b0;
        sb_if.issue_valid_i    = 1'b1;
        sb_if.issue_we_i       = 1'b1;
        sb_if.issue_waddr_i    = 5'd5;
        sb_if.issue_id_i       = 4'd1;
        sb_if.rf_re_id_i       = 2'b00;
        sb_if.rf_raddr_id_i[0] = 5'd0;
        sb_if.rf_raddr_id_i[1] = 5'd0;
        sb_if.retire_valid_i   = 1'b0;
        sb_if.retire_id_i      = 4'd0;
        repeat (2) @(posedge clk);

        // Reset with an issue pending leaves the scoreboard empty
        apply_stimulus(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        check_output("rst_empty", 32'(sb_if.empty_o), 1);
        check_output("rst_outstanding", 32'(sb_if.outstanding_o), 0);
        check_output("rst_ready", 32'(sb_if.issue_ready_o), 1);
        check_output("rst_full", 32'(sb_if.full_o), 0);
        check_output("rst_raw", 32'(sb_if.raw_hazard_o), 0);

        // RAW on x5 and same-cycle release on retire
        apply_stimulus(1, 1, 1, 5, 3, 2'b00, 0, 0, 0, 0);
        check_output("raw_issue_ready", 32'(sb_if.issue_ready_o), 1);
        check_output("raw_issue_stall", 32'(sb_if.stall_id_o), 0);
        apply_stimulus(1, 0, 0, 0, 0, 2'b01, 5, 0, 0, 0);
        check_output("raw_port0", 32'(sb_if.raw_hazard_o), 1);
        check_output("raw_stall", 32'(sb_if.stall_id_o), 1);
        check_output("raw_outstanding", 32'(sb_if.outstanding_o), 1);
        check_output("raw_empty", 32'(sb_if.empty_o), 0);
        apply_stimulus(1, 0, 0, 0, 0, 2'b10, 0, 5, 0, 0);
        check_output("raw_port1", 32'(sb_if.raw_hazard_o), 1);
        apply_stimulus(1, 0, 0, 0, 0, 2'b00, 5, 5, 0, 0);
        check_output("raw_disabled", 32'(sb_if.raw_hazard_o), 0);
        apply_stimulus(1, 0, 0, 0, 0, 2'b01, 5, 0, 1, 3);
        check_output("raw_bypass", 32'(sb_if.raw_hazard_o), 0);
        check_output("raw_bypass_stall", 32'(sb_if.stall_id_o), 0);
        apply_stimulus(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        check_output("raw_after_retire_empty", 32'(sb_if.empty_o), 1);

        // x0 writer occupies a slot but never causes hazards
        apply_stimulus(1, 1, 1, 0, 2, 2'b00, 0, 0, 0, 0);
        apply_stimulus(1, 0, 1, 0, 0, 2'b11, 0, 0, 0, 0);
        check_output("x0_raw", 32'(sb_if.raw_hazard_o), 0);
        check_output("x0_waw", 32'(sb_if.waw_hazard_o), 0);
        check_output("x0_outstanding", 32'(sb_if.outstanding_o), 1);
        check_output("x0_empty", 32'(sb_if.empty_o), 0);
        apply_stimulus(1, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2);
        apply_stimulus(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        check_output("x0_released_empty", 32'(sb_if.empty_o), 1);

        // Fill all four slots, then a refused issue during retire
        apply_stimulus(1, 1, 1, 1, 0, 2'b00, 0, 0, 0, 0);
        apply_stimulus(1, 1, 1, 2, 1, 2'b00, 0, 0, 0, 0);
        apply_stimulus(1, 1, 1, 3, 2, 2'b00, 0, 0, 0, 0);
        apply_stimulus(1, 1, 1, 4, 3, 2'b00, 0, 0, 0, 0);
        check_output("fill_3_outstanding", 32'(sb_if.outstanding_o), 3);
        apply_stimulus(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        check_output("full_flag", 32'(sb_if.full_o), 1);
        check_output("full_outstanding", 32'(sb_if.outstanding_o), 4);
        check_output("full_ready", 32'(sb_if.issue_ready_o), 0);
        apply_stimulus(1, 1, 1, 6, 4, 2'b00, 0, 0, 1, 1);
        check_output("full_retire_refused", 32'(sb_if.issue_ready_o), 0);
        check_output("full_retire_stall", 32'(sb_if.stall_id_o), 1);
        apply_stimulus(1, 1, 1, 6, 4, 2'b00, 0, 0, 0, 0);
        check_output("full_after_retire_count", 32'(sb_if.outstanding_o), 3);
        check_output("full_after_retire_ready", 32'(sb_if.issue_ready_o), 1);
        apply_stimulus(1, 0, 0, 0, 0, 2'b11, 6, 2, 0, 0);
        check_output("full_refill_outstanding", 32'(sb_if.outstanding_o), 4);
        check_output("full_refill_raw_x6", 32'(sb_if.raw_hazard_o), 1);
        apply_stimulus(1, 0, 0, 0, 0, 2'b10, 0, 2, 0, 0);
        check_output("full_retired_x2", 32'(sb_if.raw_hazard_o), 0);
        apply_stimulus(1, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
        apply_stimulus(1, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2);
        apply_stimulus(1, 0, 0, 0, 0, 2'b00, 0, 0, 1, 3);
        apply_stimulus(1, 0, 0, 0, 0, 2'b00, 0, 0, 1, 4);
        apply_stimulus(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        check_output("full_drained_empty", 32'(sb_if.empty_o), 1);

        // WAW on x7 blocks issue until the owner retires
        apply_stimulus(1, 1, 1, 7, 7, 2'b00, 0, 0, 0, 0);
        apply_stimulus(1, 1, 1, 7, 8, 2'b00, 0, 0, 0, 0);
        check_output("waw_hazard", 32'(sb_if.waw_hazard_o), 1);
        check_output("waw_ready", 32'(sb_if.issue_ready_o), 0);
        check_output("waw_stall", 32'(sb_if.stall_id_o), 1);
        apply_stimulus(1, 1, 1, 7, 8, 2'b00, 0, 0, 0, 0);
        check_output("waw_held", 32'(sb_if.waw_hazard_o), 1);
        apply_stimulus(1, 1, 1, 7, 8, 2'b00, 0, 0, 1, 7);
        check_output("waw_bypass", 32'(sb_if.waw_hazard_o), 0);
        check_output("waw_bypass_ready", 32'(sb_if.issue_ready_o), 1);
        apply_stimulus(1, 0, 0, 0, 0, 2'b01, 7, 0, 0, 0);
        check_output("waw_new_owner_count", 32'(sb_if.outstanding_o), 1);
        check_output("waw_new_owner_raw", 32'(sb_if.raw_hazard_o), 1);
        apply_stimulus(1, 0, 0, 0, 0, 2'b00, 0, 0, 1, 8);
        apply_stimulus(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        check_output("waw_drained_empty", 32'(sb_if.empty_o), 1);

        // Concurrent accept and retire keep the count and pick the lowest free slot
        apply_stimulus(1, 1, 1, 10, 1, 2'b00, 0, 0, 0, 0);
        apply_stimulus(1, 1, 1, 11, 2, 2'b00, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        check_output("conc_before", 32'(sb_if.outstanding_o), 2);
        apply_stimulus(1, 1, 1, 12, 3, 2'b00, 0, 0, 1, 1);
        check_output("conc_ready", 32'(sb_if.issue_ready_o), 1);
        apply_stimulus(1, 0, 0, 0, 0, 2'b01, 10, 0, 0, 0);
        check_output("conc_after", 32'(sb_if.outstanding_o), 2);
        check_output("conc_x10_gone", 32'(sb_if.raw_hazard_o), 0);
        apply_stimulus(1, 0, 0, 0, 0, 2'b11, 12, 11, 0, 0);
        check_output("conc_x12_x11_tracked", 32'(sb_if.raw_hazard_o), 1);
        apply_stimulus(1, 1, 1, 13, 4, 2'b00, 0, 0, 0, 0);
        apply_stimulus(1, 1, 1, 14, 5, 2'b00, 0, 0, 0, 0);
        check_output("conc_three", 32'(sb_if.outstanding_o), 3);
        check_output("conc_three_full", 32'(sb_if.full_o), 0);
        apply_stimulus(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        check_output("conc_refull", 32'(sb_if.full_o), 1);

        // Reset mid-operation discards everything despite issue/retire activity
        apply_stimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        apply_stimulus(0, 1, 1, 15, 6, 2'b00, 0, 0, 1, 2);
        apply_stimulus(1, 0, 0, 0, 0, 2'b01, 13, 0, 0, 0);
        check_output("midrst_empty", 32'(sb_if.empty_o), 1);
        check_output("midrst_outstanding", 32'(sb_if.outstanding_o), 0);
        check_output("midrst_full", 32'(sb_if.full_o), 0);
        check_output("midrst_raw", 32'(sb_if.raw_hazard_o), 0);
        check_output("midrst_ready", 32'(sb_if.issue_ready_o), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
